wb_burst_fetch: RTL and testbench

Wishbone B4 master that fetches a block of 32-bit words from a Wishbone memory slave (the `wb_bram` block RAM, or the SDRAM controller port) using incrementing bursts. Fetched words are placed in an internal FIFO and delivered on a valid/ready stream. It sits on the bus directly in front of the memory and feeds the video pixel path. Bursts are sized so the FIFO can never overflow.

---
 rtl/wb_burst_fetch.sv | 159 +++++++++++++++
 tb/tb_wb_burst_fetch.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_fetch.sv
// Wishbone B4 burst-read master: fetches a block of words into a small FIFO
// and presents them on a valid/ready stream for the pixel path.
module wb_burst_fetch #(
    parameter int LEN_WIDTH  = 11,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [31:0]          base_adr,
    input  logic [LEN_WIDTH-1:0] len,
    output logic                 busy,
    output logic                 done,
    output logic [31:0]          dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [31:0]          wb_m_adr,
    output logic                 wb_m_cyc,
    output logic                 wb_m_stb,
    output logic                 wb_m_we,
    output logic [3:0]           wb_m_sel,
    output logic [2:0]           wb_m_cti,
    output logic [1:0]           wb_m_bte,
    output logic [31:0]          wb_m_dat_ms,
    input  logic                 wb_m_ack,
    input  logic [31:0]          wb_m_dat_sm
);

    // state    | meaning
    // S_IDLE   | waiting for start; latches address and length
    // S_ARM    | waiting for FIFO space; sizes the next burst
    // S_BURST  | cyc/stb asserted, one word pushed per ack
    // S_GAP    | one idle bus cycle between bursts
    // S_FINISH | done pulse, then back to idle

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_BURST,
        S_GAP,
        S_FINISH
    } state_t;

    state_t               state_q, state_d;
    logic [29:0]          word_adr_q, word_adr_d;
    logic [LEN_WIDTH-1:0] rem_q, rem_d;
    logic [LEN_WIDTH-1:0] blen_q, blen_d;

    logic [31:0]          mem_q [FIFO_DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q;
    logic                 push;
    logic                 pop;
    logic [LEN_WIDTH-1:0] free;

    logic                 unused_adr_bits;
    assign unused_adr_bits = ^base_adr[1:0];

    assign free = LEN_WIDTH'(FIFO_DEPTH) - LEN_WIDTH'(count_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            word_adr_q <= '0;
            rem_q      <= '0;
            blen_q     <= '0;
        end else begin
            state_q    <= state_d;
            word_adr_q <= word_adr_d;
            rem_q      <= rem_d;
            blen_q     <= blen_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        word_adr_d = word_adr_q;
        rem_d      = rem_q;
        blen_d     = blen_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    word_adr_d = base_adr[31:2];
                    rem_d      = len;
                    state_d    = (len == '0) ? S_FINISH : S_ARM;
                end
            end
            S_ARM: begin
                // burst never exceeds the space seen now; pops only add more
                if (free != '0) begin
                    blen_d  = (rem_q < free) ? rem_q : free;
                    state_d = S_BURST;
                end
            end
            S_BURST: begin
                if (wb_m_ack) begin
                    push       = 1'b1;
                    word_adr_d = word_adr_q + 30'd1;
                    rem_d      = rem_q - LEN_WIDTH'(1);
                    blen_d     = blen_q - LEN_WIDTH'(1);
                    if (blen_q == LEN_WIDTH'(1)) begin
                        state_d = (rem_q == LEN_WIDTH'(1)) ? S_FINISH : S_GAP;
                    end
                end
            end
            S_GAP:    state_d = S_ARM;
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    assign wb_m_cyc    = (state_q == S_BURST);
    assign wb_m_stb    = wb_m_cyc;
    assign wb_m_adr    = {word_adr_q, 2'b00};
    assign wb_m_cti    = !wb_m_cyc                  ? 3'b000 :
                         (blen_q == LEN_WIDTH'(1))  ? 3'b111 : 3'b010;
    assign wb_m_we     = 1'b0;
    assign wb_m_sel    = 4'b1111;
    assign wb_m_bte    = 2'b00;
    assign wb_m_dat_ms = '0;

    assign busy = (state_q == S_ARM) || (state_q == S_BURST) || (state_q == S_GAP);
    assign done = (state_q == S_FINISH);

    assign dout_valid = (count_q != '0);
    assign pop        = dout_valid && dout_ready;
    assign dout       = dout_valid ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wb_m_dat_sm;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_burst_fetch.sv
// Bench for wb_burst_fetch: random-wait-state slave, random consumer, and a
// transaction-level model of the expected words, addresses and burst sizes.
module tb_wb_burst_fetch;

    localparam int DEPTH = 8;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] base_adr;
    logic [10:0] len;
    logic        busy;
    logic        done;
    logic [31:0] dout;
    logic        dout_valid;
    logic        dout_ready;
    logic [31:0] wb_m_adr;
    logic        wb_m_cyc;
    logic        wb_m_stb;
    logic        wb_m_we;
    logic [3:0]  wb_m_sel;
    logic [2:0]  wb_m_cti;
    logic [1:0]  wb_m_bte;
    logic [31:0] wb_m_dat_ms;
    logic        wb_m_ack;
    logic [31:0] wb_m_dat_sm;

    wb_burst_fetch #(.LEN_WIDTH(11), .FIFO_DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .base_adr    (base_adr),
        .len         (len),
        .busy        (busy),
        .done        (done),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .wb_m_adr    (wb_m_adr),
        .wb_m_cyc    (wb_m_cyc),
        .wb_m_stb    (wb_m_stb),
        .wb_m_we     (wb_m_we),
        .wb_m_sel    (wb_m_sel),
        .wb_m_cti    (wb_m_cti),
        .wb_m_bte    (wb_m_bte),
        .wb_m_dat_ms (wb_m_dat_ms),
        .wb_m_ack    (wb_m_ack),
        .wb_m_dat_sm (wb_m_dat_sm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] fifo_q[$];
    logic [29:0] m_adr;
    int          m_rem;
    bit          m_busy, m_done;
    int          occ, occ_prev;
    int          exp_blen, beat_in_burst;
    bit          prev_cyc, last_beat_prev;
    int          since_start;
    int          fetch_beats, delivered;
    int          ready_mode, ack_pct;
    bit          ready_latch;
    bit          req_start;
    logic [31:0] req_adr;
    int          req_len;
    int          rst_at_beat;
    bit          did_rst;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %h, expected %h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // One bus cycle: check outputs at the negedge, then drive the next edge.
    task automatic tick();
        int occ_now;
        int acc;
        int popd;
        bit nb, nd;
        @(negedge clk);
        occ_now = occ;
        if (since_start < 3) since_start++;

        chk("busy", 32'(busy), 32'(m_busy));
        chk("done", 32'(done), 32'(m_done));
        chk("dout_valid", 32'(dout_valid), 32'(occ_now > 0));
        if (occ_now > 0) chk("dout", dout, fifo_q[0]);
        if (!m_busy) chk("cyc_idle", 32'(wb_m_cyc), 32'(0));
        if (last_beat_prev) chk("cyc_after_last", 32'(wb_m_cyc), 32'(0));
        if (since_start == 1) chk("arm_no_cyc", 32'(wb_m_cyc), 32'(0));
        if (since_start == 2 && occ_prev < DEPTH) chk("stb_at_n2", 32'(wb_m_cyc), 32'(1));

        if (wb_m_cyc && !prev_cyc) begin
            exp_blen      = (m_rem < DEPTH - occ_prev) ? m_rem : DEPTH - occ_prev;
            beat_in_burst = 0;
        end
        if (wb_m_cyc) begin
            chk("stb", 32'(wb_m_stb), 32'(1));
            chk("adr", wb_m_adr, {m_adr, 2'b00});
            chk("cti", 32'(wb_m_cti), 32'((beat_in_burst == exp_blen - 1) ? 3'b111 : 3'b010));
            chk("no_stb_when_full", 32'(occ_now < DEPTH), 32'(1));
            chk("we_sel_bte_dat", 32'({wb_m_we, wb_m_sel, wb_m_bte}) ^ wb_m_dat_ms, 32'(7'b0111100));
        end
        prev_cyc       = wb_m_cyc;
        occ_prev       = occ_now;
        last_beat_prev = 1'b0;

        if (rst_at_beat >= 0 && wb_m_cyc && fetch_beats == rst_at_beat) begin
            rst_n       = 1'b0;
            start       = 1'b0;
            wb_m_ack    = 1'b0;
            dout_ready  = 1'b0;
            fifo_q.delete();
            occ         = 0;
            occ_prev    = 0;
            m_busy      = 1'b0;
            m_done      = 1'b0;
            m_rem       = 0;
            prev_cyc    = 1'b0;
            since_start = 3;
            rst_at_beat = -1;
            did_rst     = 1'b1;
            return;
        end
        rst_n = 1'b1;

        acc      = 0;
        wb_m_ack = 1'b0;
        if (wb_m_cyc && wb_m_stb && int'($urandom_range(1, 100)) <= ack_pct) begin
            wb_m_ack    = 1'b1;
            wb_m_dat_sm = 32'hA500_0000 + {2'b00, wb_m_adr[31:2]};
            fifo_q.push_back(32'hA500_0000 + {2'b00, m_adr});
            m_adr++;
            m_rem--;
            beat_in_burst++;
            fetch_beats++;
            acc = 1;
            if (beat_in_burst == exp_blen) last_beat_prev = 1'b1;
        end

        case (ready_mode)
            0: dout_ready = 1'($urandom_range(0, 1));
            1: dout_ready = 1'b1;
            default: begin
                if (occ_now == DEPTH) ready_latch = 1'b1;
                dout_ready = ready_latch;
            end
        endcase
        popd = 0;
        if (occ_now > 0 && dout_ready) begin
            void'(fifo_q.pop_front());
            delivered++;
            popd = 1;
        end
        occ = occ_now + acc - popd;
        chk("fifo_bound", 32'(occ <= DEPTH), 32'(1));

        nb = m_busy;
        nd = 1'b0;
        if (acc == 1 && m_rem == 0) begin
            nb = 1'b0;
            nd = 1'b1;
        end
        start = 1'b0;
        if (req_start) begin
            start     = 1'b1;
            base_adr  = req_adr;
            len       = 11'(req_len);
            req_start = 1'b0;
            if (!m_busy && !m_done) begin
                m_adr       = req_adr[31:2];
                m_rem       = req_len;
                fetch_beats = 0;
                if (req_len == 0) nd = 1'b1;
                else begin
                    nb          = 1'b1;
                    since_start = 0;
                end
            end
        end else begin
            base_adr = $urandom();
            len      = 11'($urandom());
        end
        m_busy = nb;
        m_done = nd;
    endtask

    task automatic run_fetch(input logic [31:0] adr, input int n, input int rmode,
                             input int apct, input int inj_at, input int rst_beat);
        int cnt;
        ready_mode  = rmode;
        ready_latch = 1'b0;
        ack_pct     = apct;
        rst_at_beat = rst_beat;
        did_rst     = 1'b0;
        delivered   = 0;
        req_adr     = adr;
        req_len     = n;
        req_start   = 1'b1;
        tick();
        cnt = 0;
        while ((m_busy || m_done || fifo_q.size() > 0) && cnt < 2000) begin
            if (cnt == inj_at && m_busy) begin
                req_adr   = adr ^ 32'h0000_8000;
                req_len   = 3;
                req_start = 1'b1;
            end
            tick();
            cnt++;
        end
        chk("timeout", 32'(cnt < 2000), 32'(1));
        if (!did_rst) chk("words_delivered", 32'(delivered), 32'(n));
        rst_at_beat = -1;
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        start       = 1'b0;
        base_adr    = '0;
        len         = '0;
        dout_ready  = 1'b0;
        wb_m_ack    = 1'b0;
        wb_m_dat_sm = '0;
        fifo_q.delete();
        m_adr = '0; m_rem = 0; m_busy = 1'b0; m_done = 1'b0;
        occ = 0; occ_prev = 0; exp_blen = 0; beat_in_burst = 0;
        prev_cyc = 1'b0; last_beat_prev = 1'b0; since_start = 3;
        fetch_beats = 0; delivered = 0; ready_mode = 1; ack_pct = 100;
        ready_latch = 1'b0; req_start = 1'b0; req_adr = '0; req_len = 0;
        rst_at_beat = -1; did_rst = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_done", 32'(done), 32'(0));
        chk("rst_cyc", 32'(wb_m_cyc), 32'(0));
        chk("rst_stb", 32'(wb_m_stb), 32'(0));
        chk("rst_dout_valid", 32'(dout_valid), 32'(0));
        chk("rst_cti", 32'(wb_m_cti), 32'(0));
        chk("rst_adr", wb_m_adr, 32'(0));
        chk("rst_dout", dout, 32'(0));

        run_fetch(32'h0000_0040, 5, 1, 100, -1, -1);
        run_fetch(32'h0000_0100, 20, 2, 100, -1, -1);
        run_fetch(32'h0000_0200, 0, 1, 100, -1, -1);
        run_fetch(32'h0000_1000, 10, 1, 60, 3, -1);
        run_fetch(32'h0000_2000, 8, 1, 100, -1, 2);
        run_fetch(32'h0000_3000, 2, 1, 100, -1, -1);
        run_fetch(32'hFFFF_FFF8, 4, 1, 100, -1, -1);

        for (int i = 0; i < 40; i++) begin
            run_fetch($urandom(), int'($urandom_range(0, 40)), int'($urandom_range(0, 1)),
                      int'($urandom_range(30, 100)),
                      ($urandom_range(0, 1) == 1) ? int'($urandom_range(1, 6)) : -1, -1);
        end

        repeat (3) tick();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
